multicycle_control_unit: RTL and testbench

//  Control FSM for the multicycle ARM-subset datapath; replaces the single-cycle controller.

---
 rtl/cu_pkg.sv | 81 ++++++++
 rtl/cu_cond_check.sv | 54 +++++
 rtl/multicycle_control_unit.sv | 140 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states, ALU ops,
// condition codes, data-processing command codes and the DP command decoder.
package cu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef struct packed {
        logic       supported;
        logic [2:0] alu_op;
        logic       no_write;
        logic       arith;      // ADD/SUB class: also updates C and V
    } dp_dec_t;

    function automatic dp_dec_t decode_dp(input logic [3:0] cmd, input logic eor_en);
        dp_dec_t d;
        d.supported = 1'b1;
        d.alu_op    = ALU_ADD;
        d.no_write  = 1'b0;
        d.arith     = 1'b0;
        case (cmd)
            CMD_ADD: begin d.alu_op = ALU_ADD; d.arith = 1'b1; end
            CMD_SUB: begin d.alu_op = ALU_SUB; d.arith = 1'b1; end
            CMD_AND: d.alu_op = ALU_AND;
            CMD_ORR: d.alu_op = ALU_ORR;
            CMD_EOR: begin d.alu_op = ALU_EOR; d.supported = eor_en; end
`ifdef CU_CMP_EN
            CMD_CMP: begin d.alu_op = ALU_SUB; d.arith = 1'b1; d.no_write = 1'b1; end
            CMD_TST: begin d.alu_op = ALU_AND; d.no_write = 1'b1; end
`endif
            default: d.supported = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cu_cond_check.sv
// NZCV flag register plus condition evaluation of Cond against the stored flags.
// Latency: CondEx is combinational from stored flags; flag writes take effect next edge.
// No backpressure: flags load whenever the per-half write enables are set.
module cu_cond_check #(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        flag_write,
    output logic              cond_ex
);
    import cu_pkg::*;

    logic [FLAG_W-1:0] flags;
    logic n, z, c, v;

    // flag_write[1] covers N/Z, flag_write[0] covers C/V
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags <= '0;
        end else begin
            if (flag_write[1]) flags[3:2] <= ALUFlags[3:2];
            if (flag_write[0]) flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign {n, z, c, v} = flags[3:0];

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset controller: FSM sequencing, ALU decode, condition-gated strobes (CU_CMP_EN adds CMP/TST).
// Latency: B 3, DP/STR 4, LDR 5, Op=11 2 cycles; outputs decode from the current state.
// No backpressure: the FSM advances every cycle; reset abandons the instruction.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 2,
    parameter int FLAG_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            Rd,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Cond,
    input  logic [FLAG_W-1:0]     ALUFlags,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl
);
    import cu_pkg::*;

    state_t     state;
    dp_dec_t    dp;
    logic       dp_ok;
    logic       cond_ex;
    logic       next_pc, branch, reg_w, mem_w, ir_write;
    logic [2:0] alu_op;
    logic [1:0] flag_w;
    logic [1:0] flag_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_DP:   state <= Funct[5] ? S_EXECI : S_EXECR;
                        OP_MEM:  state <= S_MEMADR;
                        OP_BR:   state <= S_BRANCH;
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEMADR: state <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state <= S_MEMWB;
                S_EXECR:  state <= S_ALUWB;
                S_EXECI:  state <= S_ALUWB;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Compare/test forms are only meaningful with the S bit set
    assign dp    = decode_dp(Funct[4:1], ALU_CTRL_W == 3);
    assign dp_ok = dp.supported & (Funct[0] | ~dp.no_write);

    always_comb begin
        next_pc   = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        ir_write  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        alu_op    = ALU_ADD;
        flag_w    = 2'b00;
        case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                alu_op  = Funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB = (state == S_EXECI) ? 2'b01 : 2'b00;
                alu_op  = dp_ok ? dp.alu_op : ALU_ADD;
                flag_w  = (dp_ok & Funct[0]) ? {1'b1, dp.arith} : 2'b00;
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                reg_w     = dp_ok & ~dp.no_write;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    cu_cond_check #(.FLAG_W(FLAG_W)) u_cond (
        .clk        (clk),
        .rst        (rst),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .flag_write (flag_write),
        .cond_ex    (cond_ex)
    );

    // Holding rst low kills every write strobe, even mid-instruction
    assign flag_write = {2{rst & cond_ex}} & flag_w;
    assign PCWrite    = rst & (next_pc | (cond_ex & (branch | (reg_w & (Rd == 4'd15)))));
    assign RegWrite   = rst & cond_ex & reg_w;
    assign MemWrite   = rst & cond_ex & mem_w;
    assign IRWrite    = rst & ir_write;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == OP_MEM, Op == OP_BR};
    assign ALUControl = ALU_CTRL_W'(alu_op);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed ARM-subset instructions then random ones,
// each cycle compared against a per-instruction phase model with its own NZCV copy.
module tb_multicycle_control_unit;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    Rd = '0;
    logic [1:0]    Op = '0;
    logic [5:0]    Funct = '0;
    logic [3:0]    Cond = 4'hE;
    logic [3:0]    ALUFlags = '0;
    logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]    ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [AW-1:0] ALUControl;

    multicycle_control_unit #(.ALU_CTRL_W(AW), .FLAG_W(4)) dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Op(Op), .Funct(Funct), .Cond(Cond),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] res;
        logic       a;
        logic [1:0] b;
        logic [2:0] alu;
        logic [1:0] regsrc, immsrc;
    } vec_t;

    typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EX, P_WB, P_BR} phase_t;

    vec_t obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  3'(ALUControl), RegSrc, ImmSrc};

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] mflags = '0;

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        if (c == 4'b1110) return 1'b1;
        if (c == 4'b1111) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b0;
        endcase
        return c[0] ? ~base : base;
    endfunction

    function automatic void dp_model(input logic [5:0] f, output logic ok, output logic [2:0] alu,
                                     output logic nowr, output logic arith);
        logic [3:0] cmd;
        cmd = f[4:1];
        ok = 1'b1; alu = 3'd0; nowr = 1'b0; arith = 1'b0;
        if (cmd == 4'b0100) begin alu = 3'd0; arith = 1'b1; end
        else if (cmd == 4'b0010) begin alu = 3'd1; arith = 1'b1; end
        else if (cmd == 4'b0000) alu = 3'd2;
        else if (cmd == 4'b1100) alu = 3'd3;
        else if (cmd == 4'b0001 && AW == 3) alu = 3'd4;
`ifdef CU_CMP_EN
        else if (cmd == 4'b1010 && f[0]) begin alu = 3'd1; arith = 1'b1; nowr = 1'b1; end
        else if (cmd == 4'b1000 && f[0]) begin alu = 3'd2; nowr = 1'b1; end
`endif
        else ok = 1'b0;
    endfunction

    task automatic build(input phase_t p, input logic [1:0] op, input logic [5:0] f,
                         input logic [3:0] rd, input logic ce, output vec_t e, output vec_t c);
        logic ok, nowr, arith, wr;
        logic [2:0] alu;
        dp_model(f, ok, alu, nowr, arith);
        e = '0;
        c = '0;
        c.pcw = 1'b1; c.memw = 1'b1; c.irw = 1'b1; c.regw = 1'b1;
        c.regsrc = 2'b11; c.immsrc = 2'b11;
        e.regsrc = {op == 2'b01, op == 2'b10};
        e.immsrc = op;
        case (p)
            P_F, P_D: begin
                e.pcw = (p == P_F); e.irw = (p == P_F);
                e.res = 2'b10; e.a = 1'b1; e.b = 2'b10;
                c.adr = 1'b1; c.res = 2'b11; c.a = 1'b1; c.b = 2'b11; c.alu = 3'b111;
            end
            P_MA: begin
                e.b = 2'b01; e.alu = f[3] ? 3'd0 : 3'd1;
                c.a = 1'b1; c.b = 2'b11; c.alu = 3'b111;
            end
            P_MR: begin e.adr = 1'b1; c.adr = 1'b1; end
            P_MWB: begin
                e.res = 2'b01; c.res = 2'b11;
                e.regw = ce; e.pcw = ce && (rd == 4'd15);
            end
            P_MW: begin e.adr = 1'b1; c.adr = 1'b1; e.memw = ce; end
            P_EX: begin
                e.b = f[5] ? 2'b01 : 2'b00;
                c.a = 1'b1; c.b = 2'b11;
                if (ok) begin e.alu = alu; c.alu = 3'b111; end
            end
            P_WB: begin
                wr = ce && ok && !nowr;
                e.regw = wr; e.pcw = wr && (rd == 4'd15);
                c.res = 2'b11;
            end
            P_BR: begin
                e.res = 2'b10; e.b = 2'b01; e.pcw = ce;
                c.res = 2'b11; c.a = 1'b1; c.b = 2'b11; c.alu = 3'b111;
            end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input vec_t e, input vec_t c);
        logic [16:0] ov, ev, cv;
        ov = obs; ev = e; cv = c;
        n_checks++;
        assert ((ov & cv) === (ev & cv)) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h (mask %h)", tag, ov & cv, ev & cv, cv);
        end
    endtask

    // Called at posedge+1 with the DUT in FETCH; stop_at > 0 leaves after that many cycles.
    task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input logic [3:0] cnd, input logic [3:0] af,
                             input int stop_at);
        phase_t seq[$];
        vec_t e, c;
        logic ce, ok, nowr, arith;
        logic [2:0] alu;
        Op = op; Funct = f; Rd = rd; Cond = cnd; ALUFlags = af;
        seq = {P_F, P_D};
        case (op)
            2'b00: begin seq.push_back(P_EX); seq.push_back(P_WB); end
            2'b01: begin
                seq.push_back(P_MA);
                if (f[0]) begin seq.push_back(P_MR); seq.push_back(P_MWB); end
                else seq.push_back(P_MW);
            end
            2'b10: seq.push_back(P_BR);
            default: ;
        endcase
        dp_model(f, ok, alu, nowr, arith);
        for (int i = 0; i < seq.size(); i++) begin
            if (stop_at != 0 && i == stop_at) break;
            @(negedge clk);
            ce = cond_model(cnd, mflags);
            build(seq[i], op, f, rd, ce, e, c);
            check($sformatf("%s/c%0d", name, i), e, c);
            if (seq[i] == P_EX && ok && f[0] && ce) begin
                mflags[3:2] = af[3:2];
                if (arith) mflags[1:0] = af[1:0];
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        vec_t e, c;
        @(negedge clk);
        build(P_F, Op, Funct, Rd, 1'b0, e, c);
        e.pcw = 1'b0;
        e.irw = 1'b0;
        check(tag, e, c);
    endtask

    initial begin
        check_reset("rst_hold");
        @(posedge clk); #1;
        rst = 1'b1;
        mflags = '0;

        run_instr("add_r0",   2'b00, 6'b001000, 4'd0,  4'hE, 4'h0, 0);
        run_instr("ldr",      2'b01, 6'b011001, 4'd2,  4'hE, 4'h0, 0);
        run_instr("str_u0",   2'b01, 6'b010000, 4'd3,  4'hE, 4'h0, 0);
        run_instr("adds_z",   2'b00, 6'b001001, 4'd1,  4'hE, 4'b0100, 0);
        run_instr("beq_tkn",  2'b10, 6'b000000, 4'd0,  4'h0, 4'h0, 0);
        run_instr("adds_nz",  2'b00, 6'b001001, 4'd1,  4'hE, 4'b0000, 0);
        run_instr("beq_not",  2'b10, 6'b000000, 4'd0,  4'h0, 4'h0, 0);
        run_instr("cmp",      2'b00, 6'b010101, 4'd0,  4'hE, 4'b0100, 0);
        run_instr("beq_cmp",  2'b10, 6'b000000, 4'd0,  4'h0, 4'h0, 0);
        run_instr("add_pc",   2'b00, 6'b001000, 4'd15, 4'hE, 4'h0, 0);
        run_instr("ldr_pc",   2'b01, 6'b011001, 4'd15, 4'hE, 4'h0, 0);
        run_instr("nop_op3",  2'b11, 6'b101010, 4'd4,  4'hE, 4'h0, 0);
        run_instr("add_nv",   2'b00, 6'b001000, 4'd5,  4'hF, 4'h0, 0);
        run_instr("eors",     2'b00, 6'b000011, 4'd6,  4'hE, 4'hF, 0);
        run_instr("beq_eor",  2'b10, 6'b000000, 4'd0,  4'h0, 4'h0, 0);
        run_instr("orri",     2'b00, 6'b111000, 4'd7,  4'hE, 4'h0, 0);

        run_instr("add_ex",   2'b00, 6'b001001, 4'd5,  4'hE, 4'hF, 2);
        rst = 1'b0;
        check_reset("rst_mid_exec");
        mflags = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        run_instr("add_wb",   2'b00, 6'b001000, 4'd15, 4'hE, 4'h0, 3);
        rst = 1'b0;
        check_reset("rst_mid_wb");
        mflags = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        run_instr("after_rst", 2'b10, 6'b000000, 4'd0, 4'h0, 4'h0, 0);

        for (int k = 0; k < 250; k++) begin
            logic [1:0] rop;
            logic [5:0] rf;
            logic [3:0] rrd, rcnd, raf;
            rop  = 2'($urandom_range(0, 3));
            rf   = 6'($urandom);
            rrd  = 4'($urandom);
            rcnd = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
            raf  = 4'($urandom);
            run_instr($sformatf("rnd%0d", k), rop, rf, rrd, rcnd, raf, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
